// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the RV32 pipeline hazard logic: forwarding-select
// encodings and the default register-index width.
package riscv_pipe_pkg;

  localparam int DEF_REG_ADDR_W = 5;

  localparam logic [1:0] FWD_RF = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_W  = 2'b01;  // operand from W-stage result
  localparam logic [1:0] FWD_M  = 2'b10;  // operand from M-stage result

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard for registers owed by the long-latency MDU.
// One set port (issue), one clear port (completion), two lookup ports.
// A same-cycle set and clear on one index leaves the bit set; bit 0 never sets.
module reg_scoreboard
  import riscv_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_set_en,
  input  logic [REG_ADDR_W-1:0] i_set_idx,
  input  logic                  i_clr_en,
  input  logic [REG_ADDR_W-1:0] i_clr_idx,
  input  logic [REG_ADDR_W-1:0] i_rd_idx_a,
  input  logic [REG_ADDR_W-1:0] i_rd_idx_b,
  output logic                  o_busy_a,
  output logic                  o_busy_b
);

  localparam int NREG = 2 ** REG_ADDR_W;

  logic [NREG-1:0] r_sb;
  logic [NREG-1:0] w_sb_nxt;

  // Next scoreboard value: clear first so a coincident set takes priority.
  always_comb begin
    w_sb_nxt = r_sb;
    if (i_clr_en) begin
      w_sb_nxt[i_clr_idx] = 1'b0;
    end
    if (i_set_en && (i_set_idx != '0)) begin
      w_sb_nxt[i_set_idx] = 1'b1;
    end
    w_sb_nxt[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb <= '0;
    end else begin
      r_sb <= w_sb_nxt;
    end
  end

  assign o_busy_a = r_sb[i_rd_idx_a];
  assign o_busy_b = r_sb[i_rd_idx_b];

endmodule

// File: rtl/hazard_ctrl_sb.sv
// Hazard unit for the 5-stage RV32 pipeline: two-source forwarding,
// multi-cycle load-use stall, and MDU scoreboard stall. A taken branch in E
// cancels the stalls and the pending load count. All outputs are forced
// low while reset is held.
module hazard_ctrl_sb
  import riscv_pipe_pkg::*;
#(
  parameter int REG_ADDR_W     = DEF_REG_ADDR_W,
  parameter int LOAD_STALL_CYC = 1,
  parameter int CNT_W          = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] i_rs1_d,
  input  logic [REG_ADDR_W-1:0] i_rs2_d,
  input  logic [REG_ADDR_W-1:0] i_rs1_e,
  input  logic [REG_ADDR_W-1:0] i_rs2_e,
  input  logic [REG_ADDR_W-1:0] i_rd_e,
  input  logic [REG_ADDR_W-1:0] i_rd_m,
  input  logic [REG_ADDR_W-1:0] i_rd_w,
  input  logic                  i_reg_write_m,
  input  logic                  i_reg_write_w,
  input  logic                  i_result_src_e0,
  input  logic                  i_pc_src_e,
  input  logic                  i_mdu_issue_e,
  input  logic                  i_mdu_done,
  input  logic [REG_ADDR_W-1:0] i_mdu_rd,
  output logic [1:0]            o_forward_a_e,
  output logic [1:0]            o_forward_b_e,
  output logic                  o_stall_f,
  output logic                  o_stall_d,
  output logic                  o_flush_d,
  output logic                  o_flush_e,
  output logic                  o_load_stall,
  output logic                  o_sb_stall
);

  localparam logic [CNT_W-1:0] LOAD_RELOAD = CNT_W'(LOAD_STALL_CYC - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_lu;
  logic             w_load_stall;
  logic             w_sb_stall;
  logic             w_flush_e;
  logic             w_busy_a;
  logic             w_busy_b;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;

  // M-stage result is the younger one, so it beats W.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] src,
    input logic [REG_ADDR_W-1:0] rd_m,
    input logic                  wr_m,
    input logic [REG_ADDR_W-1:0] rd_w,
    input logic                  wr_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if ((src == rd_m) && wr_m && (src != '0)) begin
      sel = FWD_M;
    end else if ((src == rd_w) && wr_w && (src != '0)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

  // Forwarding selects and combinational hazard detection.
  always_comb begin
    w_fwd_a      = fwd_sel(i_rs1_e, i_rd_m, i_reg_write_m, i_rd_w, i_reg_write_w);
    w_fwd_b      = fwd_sel(i_rs2_e, i_rd_m, i_reg_write_m, i_rd_w, i_reg_write_w);
    w_lu         = i_result_src_e0 && (i_rd_e != '0) &&
                   ((i_rs1_d == i_rd_e) || (i_rs2_d == i_rd_e));
    w_load_stall = w_lu || (r_cnt != '0);
    w_sb_stall   = w_busy_a || w_busy_b;
    w_flush_e    = i_pc_src_e || w_load_stall || w_sb_stall;
  end

  // Remaining load-use stall cycles after the detecting cycle; a taken
  // branch discards whatever is left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_pc_src_e) begin
      r_cnt <= '0;
    end else if (w_lu) begin
      r_cnt <= LOAD_RELOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // An MDU op squashed in E never reaches the unit, so it must not mark busy.
  reg_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_set_en   (i_mdu_issue_e && !w_flush_e),
    .i_set_idx  (i_rd_e),
    .i_clr_en   (i_mdu_done),
    .i_clr_idx  (i_mdu_rd),
    .i_rd_idx_a (i_rs1_d),
    .i_rd_idx_b (i_rs2_d),
    .o_busy_a   (w_busy_a),
    .o_busy_b   (w_busy_b)
  );

  // Output drive, held low while reset is asserted.
  always_comb begin
    o_forward_a_e = FWD_RF;
    o_forward_b_e = FWD_RF;
    o_stall_f     = 1'b0;
    o_stall_d     = 1'b0;
    o_flush_d     = 1'b0;
    o_flush_e     = 1'b0;
    o_load_stall  = 1'b0;
    o_sb_stall    = 1'b0;
    if (rst_n) begin
      o_forward_a_e = w_fwd_a;
      o_forward_b_e = w_fwd_b;
      o_stall_f     = (w_load_stall || w_sb_stall) && !i_pc_src_e;
      o_stall_d     = (w_load_stall || w_sb_stall) && !i_pc_src_e;
      o_flush_d     = i_pc_src_e;
      o_flush_e     = w_flush_e;
      o_load_stall  = w_load_stall;
      o_sb_stall    = w_sb_stall;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Bench for hazard_ctrl_sb: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a rule-level model.
module tb_hazard_ctrl_sb;

  localparam int AW  = 5;
  localparam int LSC = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, mdu_rd;
  logic          reg_write_m, reg_write_w, result_src_e0, pc_src_e;
  logic          mdu_issue_e, mdu_done;
  logic [1:0]    forward_a_e, forward_b_e;
  logic          stall_f, stall_d, flush_d, flush_e, load_stall, sb_stall;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: busy set of registers and remaining load stall cycles.
  bit [31:0] m_sb, nxt_sb;
  int        m_cnt, nxt_cnt;

  always #5 clk = ~clk;

  hazard_ctrl_sb #(
    .REG_ADDR_W     (AW),
    .LOAD_STALL_CYC (LSC),
    .CNT_W          (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_rs1_d         (rs1_d),
    .i_rs2_d         (rs2_d),
    .i_rs1_e         (rs1_e),
    .i_rs2_e         (rs2_e),
    .i_rd_e          (rd_e),
    .i_rd_m          (rd_m),
    .i_rd_w          (rd_w),
    .i_reg_write_m   (reg_write_m),
    .i_reg_write_w   (reg_write_w),
    .i_result_src_e0 (result_src_e0),
    .i_pc_src_e      (pc_src_e),
    .i_mdu_issue_e   (mdu_issue_e),
    .i_mdu_done      (mdu_done),
    .i_mdu_rd        (mdu_rd),
    .o_forward_a_e   (forward_a_e),
    .o_forward_b_e   (forward_b_e),
    .o_stall_f       (stall_f),
    .o_stall_d       (stall_d),
    .o_flush_d       (flush_d),
    .o_flush_e       (flush_e),
    .o_load_stall    (load_stall),
    .o_sb_stall      (sb_stall)
  );

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_fwd(input int s);
    if (s != 0 && s == rd_m && reg_write_m) return 2'b10;
    if (s != 0 && s == rd_w && reg_write_w) return 2'b01;
    return 2'b00;
  endfunction

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    logic [1:0] e_fa, e_fb;
    logic e_sf, e_fd, e_fe, e_ls, e_sbs, lu;
    if (!rst_n) begin
      e_fa = 0; e_fb = 0; e_sf = 0; e_fd = 0; e_fe = 0; e_ls = 0; e_sbs = 0;
      nxt_cnt = 0;
      nxt_sb  = 0;
    end else begin
      e_fa  = m_fwd(int'(rs1_e));
      e_fb  = m_fwd(int'(rs2_e));
      lu    = result_src_e0 && rd_e != 0 && (rs1_d == rd_e || rs2_d == rd_e);
      e_ls  = lu || (m_cnt > 0);
      e_sbs = m_sb[rs1_d] || m_sb[rs2_d];
      e_sf  = (e_ls || e_sbs) && !pc_src_e;
      e_fd  = pc_src_e;
      e_fe  = pc_src_e || e_ls || e_sbs;
      if (pc_src_e)      nxt_cnt = 0;
      else if (lu)       nxt_cnt = LSC - 1;
      else if (m_cnt > 0) nxt_cnt = m_cnt - 1;
      else               nxt_cnt = 0;
      nxt_sb = m_sb;
      if (mdu_done) nxt_sb[mdu_rd] = 1'b0;
      if (mdu_issue_e && rd_e != 0 && !e_fe) nxt_sb[rd_e] = 1'b1;
    end
    chk("model.forward_a_e", forward_a_e, e_fa);
    chk("model.forward_b_e", forward_b_e, e_fb);
    chk("model.stall_f", {1'b0, stall_f}, {1'b0, e_sf});
    chk("model.stall_d", {1'b0, stall_d}, {1'b0, e_sf});
    chk("model.flush_d", {1'b0, flush_d}, {1'b0, e_fd});
    chk("model.flush_e", {1'b0, flush_e}, {1'b0, e_fe});
    chk("model.load_stall", {1'b0, load_stall}, {1'b0, e_ls});
    chk("model.sb_stall", {1'b0, sb_stall}, {1'b0, e_sbs});
  end

  // Model state update.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0;
      m_sb  <= 0;
    end else begin
      m_cnt <= nxt_cnt;
      m_sb  <= nxt_sb;
    end
  end

  task automatic idle();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    mdu_rd = 0; reg_write_m = 0; reg_write_w = 0; result_src_e0 = 0;
    pc_src_e = 0; mdu_issue_e = 0; mdu_done = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #2;
    chk("reset.stall_f", {1'b0, stall_f}, 2'b00);
    chk("reset.flush_e", {1'b0, flush_e}, 2'b00);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // Forwarding, M beats W, x0 never forwarded.
    rs1_e = 5; rs2_e = 5; rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1;
    settle();
    chk("fwd.a_M", forward_a_e, 2'b10);
    chk("fwd.b_M", forward_b_e, 2'b10);
    rs1_e = 0;
    settle();
    chk("fwd.a_x0", forward_a_e, 2'b00);
    chk("fwd.b_M2", forward_b_e, 2'b10);
    reg_write_m = 0;
    settle();
    chk("fwd.b_W", forward_b_e, 2'b01);
    cyc(); idle(); cyc();

    // Load-use, three stall cycles.
    result_src_e0 = 1; rd_e = 7; rs2_d = 7;
    settle();
    chk("lu.c1.load_stall", {1'b0, load_stall}, 2'b01);
    chk("lu.c1.stall_f", {1'b0, stall_f}, 2'b01);
    chk("lu.c1.stall_d", {1'b0, stall_d}, 2'b01);
    chk("lu.c1.flush_e", {1'b0, flush_e}, 2'b01);
    cyc(); result_src_e0 = 0; rd_e = 0; settle();
    chk("lu.c2.load_stall", {1'b0, load_stall}, 2'b01);
    cyc(); settle();
    chk("lu.c3.load_stall", {1'b0, load_stall}, 2'b01);
    cyc(); settle();
    chk("lu.c4.load_stall", {1'b0, load_stall}, 2'b00);
    chk("lu.c4.flush_e", {1'b0, flush_e}, 2'b00);
    cyc();

    // Load to x0 never stalls.
    result_src_e0 = 1; rd_e = 0; rs2_d = 0; settle();
    chk("lu.x0.load_stall", {1'b0, load_stall}, 2'b00);
    cyc(); idle(); cyc();

    // Scoreboard stall across MDU latency.
    mdu_issue_e = 1; rd_e = 9; settle();
    chk("sb.issue.sb_stall", {1'b0, sb_stall}, 2'b00);
    cyc(); idle(); rs1_d = 9; settle();
    chk("sb.wait.sb_stall", {1'b0, sb_stall}, 2'b01);
    chk("sb.wait.stall_d", {1'b0, stall_d}, 2'b01);
    cyc(); mdu_done = 1; mdu_rd = 9; settle();
    chk("sb.done.sb_stall", {1'b0, sb_stall}, 2'b01);
    cyc(); mdu_done = 0; settle();
    chk("sb.after.sb_stall", {1'b0, sb_stall}, 2'b00);
    cyc(); idle();

    // Same-cycle issue and done on one index: stays busy.
    mdu_issue_e = 1; rd_e = 9; cyc();
    mdu_done = 1; mdu_rd = 9; cyc();
    idle(); rs1_d = 9; settle();
    chk("sb.setwins.sb_stall", {1'b0, sb_stall}, 2'b01);
    mdu_done = 1; mdu_rd = 9; cyc(); idle(); cyc();

    // Branch in E during cycle 2 of a load stall.
    result_src_e0 = 1; rd_e = 7; rs1_d = 7; cyc();
    result_src_e0 = 0; rd_e = 0; pc_src_e = 1; settle();
    chk("br.stall_f", {1'b0, stall_f}, 2'b00);
    chk("br.stall_d", {1'b0, stall_d}, 2'b00);
    chk("br.flush_d", {1'b0, flush_d}, 2'b01);
    chk("br.flush_e", {1'b0, flush_e}, 2'b01);
    cyc(); pc_src_e = 0; settle();
    chk("br.next.load_stall", {1'b0, load_stall}, 2'b00);
    cyc(); idle();

    // Async reset with busy bits 3 and 12.
    mdu_issue_e = 1; rd_e = 3; cyc();
    rd_e = 12; cyc();
    idle(); rs1_d = 3; rs2_d = 12; rs1_e = 5; rd_m = 5; reg_write_m = 1; settle();
    chk("rst.pre.sb_stall", {1'b0, sb_stall}, 2'b01);
    rst_n = 1'b0; settle();
    chk("rst.mid.sb_stall", {1'b0, sb_stall}, 2'b00);
    chk("rst.mid.stall_f", {1'b0, stall_f}, 2'b00);
    chk("rst.mid.forward_a_e", forward_a_e, 2'b00);
    rst_n = 1'b1; settle();
    chk("rst.post.sb_stall", {1'b0, sb_stall}, 2'b00);
    cyc(); idle(); rs1_d = 12; settle();
    chk("rst.post12.sb_stall", {1'b0, sb_stall}, 2'b00);
    cyc();

    // Randomized traffic; small index range to provoke collisions.
    for (int i = 0; i < 3000; i++) begin
      rst_n         = ($urandom_range(0, 299) != 0);
      rs1_d         = AW'($urandom_range(0, 7));
      rs2_d         = AW'($urandom_range(0, 7));
      rs1_e         = AW'($urandom_range(0, 7));
      rs2_e         = AW'($urandom_range(0, 7));
      rd_e          = AW'($urandom_range(0, 7));
      rd_m          = AW'($urandom_range(0, 7));
      rd_w          = AW'($urandom_range(0, 7));
      mdu_rd        = AW'($urandom_range(0, 7));
      reg_write_m   = $urandom_range(0, 1) == 1;
      reg_write_w   = $urandom_range(0, 1) == 1;
      result_src_e0 = $urandom_range(0, 3) == 0;
      pc_src_e      = $urandom_range(0, 7) == 0;
      mdu_issue_e   = $urandom_range(0, 3) == 0;
      mdu_done      = $urandom_range(0, 3) == 0;
      cyc();
    end
    rst_n = 1'b1;
    idle();
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_sb.md
Name: hazard_ctrl_sb

Overview:
- Parametrised hazard unit for the 5-stage RV32 pipeline; successor of the single-operand, fixed-latency hazard logic.
- Same-cycle forwarding for both E-stage sources (rs1, rs2).
- Multi-cycle load-use stall counter for slow data memory.
- Register scoreboard that stalls Decode on operands still owed by the long-latency multiply/divide unit (MDU); control-hazard flush overrides all stalls.

Parameters:
- REG_ADDR_W, 5, register-index width; scoreboard has 2**REG_ADDR_W bits.
- LOAD_STALL_CYC, 1, stall cycles per load-use hazard (>=1).
- CNT_W, 4, width of load stall counter; must hold LOAD_STALL_CYC.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- rs1_d, rs2_d  in  REG_ADDR_W  D-stage source indices
- rs1_e, rs2_e, rd_e  in  REG_ADDR_W  E-stage sources/destination
- rd_m, rd_w  in  REG_ADDR_W  M/W destinations
- reg_write_m, reg_write_w  in  1  M/W write enables
- result_src_e0  in  1  E-stage instruction is a load
- pc_src_e  in  1  taken branch/jump resolved in E
- mdu_issue_e  in  1  MDU op in E issues this cycle (destination rd_e)
- mdu_done  in  1  MDU writes back this cycle
- mdu_rd  in  REG_ADDR_W  destination of completing MDU op
- forward_a_e, forward_b_e  out  2  00=regfile, 10=from M, 01=from W
- stall_f, stall_d, flush_d, flush_e  out  1  pipeline controls
- load_stall, sb_stall  out  1  stall cause, for debug/perf counters

Behaviour:
- Reset (rst_n low, async): scoreboard all 0, load counter 0. All outputs 0 while reset is held, since no hazards are latched.
- Forwarding (combinational, per source s in {rs1_e, rs2_e}):
  - 10 if s==rd_m & reg_write_m & s!=0.
  - Else 01 if s==rd_w & reg_write_w & s!=0.
  - Else 00.
  - M has priority over W.
- Load-use detect (combinational): lu = result_src_e0 & rd_e!=0 & (rs1_d==rd_e | rs2_d==rd_e).
- Load counter: on lu & !pc_src_e, load LOAD_STALL_CYC-1. Otherwise, if >0 and !pc_src_e, decrement. A pc_src_e cycle clears it to 0.
- load_stall = lu | (cnt!=0).
  - LOAD_STALL_CYC=1 gives the classic single bubble.
  - LOAD_STALL_CYC=N gives exactly N consecutive stall cycles.
- Scoreboard (registered):
  - Bit r set on mdu_issue_e & rd_e!=0 & !flush_e.
  - Bit r cleared on mdu_done (mdu_rd).
  - Issue and done on the same index in the same cycle: set wins.
  - Bit 0 is never set.
- sb_stall = scoreboard[rs1_d] | scoreboard[rs2_d], using the current registered value.
  - mdu_done this cycle does not release the stall until the next cycle, since the W value is then forwardable/in the regfile.
- stall_f = stall_d = (load_stall | sb_stall) & !pc_src_e.
- flush_d = pc_src_e.
- flush_e = pc_src_e | load_stall | sb_stall. E receives a bubble on every stall cycle.
- pc_src_e during a stall:
  - Stall drops in that cycle and the counter cancels.
  - Scoreboard bits for already-issued MDU ops remain; the op completes.
- Reset asserted mid-stall: all state cleared immediately; stalls drop asynchronously.

Decomposition:
- Shared pkg (riscv_pipe_pkg) holds:
  - FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - REG_ADDR_W default.
- Sub-module: reg_scoreboard (set/clear/lookup of 2**REG_ADDR_W bits, two read ports).
- Forwarding mux-select and counter stay in the top.

Test Plan:
- rs1_e=rs2_e=5, rd_m=5, reg_write_m=1, rd_w=5, reg_write_w=1 -> forward_a_e=forward_b_e=10. Repeat with rs1_e=0 -> forward_a_e=00.
- Load in E, rd_e=7, rs2_d=7, LOAD_STALL_CYC=3 -> load_stall, stall_f, stall_d, flush_e high for exactly 3 cycles, then 0.
- Same load with rd_e=0 -> no stall.
- mdu_issue_e with rd_e=9; next cycle rs1_d=9 -> sb_stall=1 until the cycle after mdu_done with mdu_rd=9, then 0.
- Same-cycle issue and done for index 9 -> bit stays set.
- Load-use stall in progress (cycle 2 of 3) plus pc_src_e=1 -> stall_f=stall_d=0, flush_d=flush_e=1; next cycle load_stall=0.
- Scoreboard bits 3 and 12 set, rst_n pulsed low mid-cycle -> outputs 0 immediately; after release rs1_d=3 gives sb_stall=0.
